// File: rtl/debug_trace_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : debug_trace_capture_if
//  Description : Probe, configuration and readout signals of the trace
//                capture block, bundled for port connection.
//                master : the side that drives probes/config and consumes
//                         readout (host, VIO, testbench)
//                slave  : the trace capture block itself
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  v_debug_in    probe bus, channel k = bits [k*CH_W +: CH_W]
//  v_arm         pulse: latch config, clear buffer, start capture
//  v_force_trig  pulse: manual trigger
//  v_trig_sel    trigger channel index (>= NUM_CH disables compare)
//  v_trig_mask   compare mask (1 = bit compared)
//  v_trig_value  compare value
//  v_post_cnt    samples stored after the trigger sample
//  v_rd_en       pulse: request next stored sample
//  v_rd_data     read sample
//  v_rd_valid    v_rd_data valid
//  v_rd_last     high with the final stored sample
//  v_state       0 IDLE, 1 ARMED, 2 POST, 3 DONE
//  v_trig_pos    read index of the trigger sample (0 = oldest)
// ============================================================================
interface debug_trace_capture_if #(
  parameter int NUM_CH     = 5,
  parameter int CH_W       = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic [NUM_CH*CH_W-1:0] v_debug_in;
  logic                   v_arm;
  logic                   v_force_trig;
  logic [7:0]             v_trig_sel;
  logic [CH_W-1:0]        v_trig_mask;
  logic [CH_W-1:0]        v_trig_value;
  logic [DEPTH_LOG2-1:0]  v_post_cnt;
  logic                   v_rd_en;
  logic [NUM_CH*CH_W-1:0] v_rd_data;
  logic                   v_rd_valid;
  logic                   v_rd_last;
  logic [1:0]             v_state;
  logic [DEPTH_LOG2-1:0]  v_trig_pos;

  modport master (
    output v_debug_in, v_arm, v_force_trig, v_trig_sel, v_trig_mask,
           v_trig_value, v_post_cnt, v_rd_en,
    input  v_rd_data, v_rd_valid, v_rd_last, v_state, v_trig_pos
  );

  modport slave (
    input  v_debug_in, v_arm, v_force_trig, v_trig_sel, v_trig_mask,
           v_trig_value, v_post_cnt, v_rd_en,
    output v_rd_data, v_rd_valid, v_rd_last, v_state, v_trig_pos
  );
endinterface
`default_nettype wire

// File: rtl/debug_trace_capture.sv
`default_nettype none
// ============================================================================
//  Module      : debug_trace_capture
//  Description : On-chip trace buffer. Captures NUM_CH probe channels of CH_W
//                bits into a circular buffer of 2**DEPTH_LOG2 samples,
//                triggers on a masked compare (or a manual pulse), stores a
//                programmable number of post-trigger samples and streams the
//                buffer out oldest-first through a read pulse handshake.
//                Passive: it never drives the observed datapath.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    v_clk0  capture/system clock
//    v_rst0  synchronous active-high reset
//    bus     debug_trace_capture_if.slave (probe, config, readout)
//  Build option
//    DEBUG_TRACE_EDGE_TRIG_EN  defined  : trigger on the rising edge of the
//                                         compare condition
//                              undefined: level trigger
// ============================================================================
module debug_trace_capture #(
  parameter int NUM_CH     = 5,
  parameter int CH_W       = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  wire logic              v_clk0,
  input  wire logic              v_rst0,
  debug_trace_capture_if.slave   bus
);

  localparam int W     = NUM_CH * CH_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] ONE_LEFT   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          probe_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, trig_addr, post_left, trig_pos;
  logic [DEPTH_LOG2:0]   count, rd_idx;
  logic [7:0]            sel_q;
  logic [CH_W-1:0]       mask_q, value_q;
  logic [DEPTH_LOG2-1:0] post_q;
  logic [W-1:0]          rd_data;
  logic                  rd_valid, rd_last;

  logic [CH_W-1:0]       chan;
  logic                  sel_ok, match, trig_hit, fire;
  logic                  wr_en, rd_go, enter_done;
  logic [DEPTH_LOG2:0]   count_inc;
  logic [DEPTH_LOG2-1:0] wr_ptr_inc, oldest, trig_final;

`ifdef DEBUG_TRACE_EDGE_TRIG_EN
  logic                  prev_match;
`endif

  // Trigger evaluation on the registered sample (the one written this cycle)
  always_comb begin
    chan   = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_q == 8'(k)) begin
        chan   = probe_q[k*CH_W +: CH_W];
        sel_ok = 1'b1;
      end
    end
    match = sel_ok && ((chan & mask_q) == (value_q & mask_q));
`ifdef DEBUG_TRACE_EDGE_TRIG_EN
    trig_hit = match && !prev_match;
`else
    trig_hit = match;
`endif
  end

  assign fire  = (state == S_ARMED) && (trig_hit || bus.v_force_trig);
  assign wr_en = !bus.v_arm && ((state == S_ARMED) || (state == S_POST));
  assign rd_go = (state == S_DONE) && !bus.v_arm && bus.v_rd_en && (rd_idx != count);

  // Values as they will stand after this cycle's write; used when the
  // capture completes so the readout start and trigger index are exact.
  assign wr_ptr_inc = wr_ptr + ONE_LEFT;
  assign count_inc  = (count == FULL_COUNT) ? count : count + 1'b1;
  assign oldest     = (count_inc == FULL_COUNT) ? wr_ptr_inc : '0;
  assign trig_final = (state == S_ARMED) ? wr_ptr : trig_addr;
  assign enter_done = (state_nx == S_DONE) && (state != S_DONE);

  // FSM state register
  always_ff @(posedge v_clk0) begin
    if (v_rst0) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state; arm restarts capture from any state
  always_comb begin
    state_nx = state;
    if (bus.v_arm) begin
      state_nx = S_ARMED;
    end else begin
      case (state)
        S_ARMED: if (fire) state_nx = (post_q == '0) ? S_DONE : S_POST;
        S_POST:  if (post_left == ONE_LEFT) state_nx = S_DONE;
        default: state_nx = state;
      endcase
    end
  end

  // Sample storage, kept free of reset so it maps onto block RAM.
  // post_cnt is DEPTH_LOG2 wide, so it can never exceed DEPTH-1.
  always_ff @(posedge v_clk0) begin
    if (wr_en && !v_rst0) mem[wr_ptr] <= probe_q;
  end

  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      probe_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_idx    <= '0;
      trig_addr <= '0;
      post_left <= '0;
      trig_pos  <= '0;
      sel_q     <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      post_q    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
`ifdef DEBUG_TRACE_EDGE_TRIG_EN
      prev_match <= 1'b1;
`endif
    end else begin
      probe_q  <= bus.v_debug_in;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (bus.v_arm) begin
        sel_q   <= bus.v_trig_sel;
        mask_q  <= bus.v_trig_mask;
        value_q <= bus.v_trig_value;
        post_q  <= bus.v_post_cnt;
        wr_ptr  <= '0;
        count   <= '0;
        rd_idx  <= '0;
`ifdef DEBUG_TRACE_EDGE_TRIG_EN
        // History starts as "matching": a condition already true at arm
        // must first drop before it can produce an edge.
        prev_match <= 1'b1;
`endif
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr_inc;
          count  <= count_inc;
        end
`ifdef DEBUG_TRACE_EDGE_TRIG_EN
        if (state == S_ARMED) prev_match <= match;
`endif
        if (fire) begin
          trig_addr <= wr_ptr;
          post_left <= post_q;
        end
        if (state == S_POST) post_left <= post_left - ONE_LEFT;
        if (enter_done) begin
          rd_ptr   <= oldest;
          rd_idx   <= '0;
          trig_pos <= trig_final - oldest;
        end
        if (rd_go) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
          rd_last  <= (rd_idx == count - 1'b1);
          rd_ptr   <= rd_ptr + ONE_LEFT;
          rd_idx   <= rd_idx + 1'b1;
        end
      end
    end
  end

  assign bus.v_rd_data  = rd_data;
  assign bus.v_rd_valid = rd_valid;
  assign bus.v_rd_last  = rd_last;
  assign bus.v_state    = state;
  assign bus.v_trig_pos = trig_pos;

endmodule
`default_nettype wire
